// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer
//   Arbitrates the instruction-fetch port (port 0, read only) and the load/store
//   port (port 1) for a 16-bit multiplexed external memory bus. Each access runs
//   low-address latch -> high-address latch -> data phase -> end, with all pad
//   and handshake outputs registered.
//
// Handshake: a requester raises reqN and holds its address (and for port 1
//   we1/be1/wdata1) stable until ackN. ackN is a one-cycle pulse. Read data on
//   rdata is valid in the ack cycle and stays valid until the next read completes.
//   Dropping reqN mid-access does not cancel it. Reset abandons an access with no ack.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req0, addr0, ack0     port 0 request / address / completion pulse
//   req1, addr1, we1,
//   be1, wdata1, ack1     port 1 request / address / write flag / byte lanes /
//                         write data / completion pulse
//   rdata                 read data shared by both ports
//   bus_in, bus_out       pad input / pad output
//   bus_dir               1 = pads are inputs, 0 = chip drives bus_out
//   le_lo, le_hi          address latch enables, active high
//   OEb, WEb_lo, WEb_hi   memory output / byte write enables, active low
//   state                 current FSM state, for observation only
module ext_bus_sequencer #(
  parameter int ADDR_W      = 24,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [1:0]        be1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata,
  input  logic [15:0]       bus_in,
  output logic [15:0]       bus_out,
  output logic              bus_dir,
  output logic              le_lo,
  output logic              le_hi,
  output logic              OEb,
  output logic              WEb_lo,
  output logic              WEb_hi,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALA  = 3'd1,
    S_ALH  = 3'd2,
    S_AHA  = 3'd3,
    S_AHH  = 3'd4,
    S_DATA = 3'd5,
    S_END  = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic              grant_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        be_q;
  logic [15:0]       wdata_q;
  logic [3:0]        cnt_q;

  logic              any_req, grant_sel, data_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       lo_word, hi_word;

  logic [15:0] bus_out_d;
  logic        bus_dir_d, le_lo_d, le_hi_d, oeb_d, web_lo_d, web_hi_d, ack0_d, ack1_d;

  // Round robin: on a tie the port that did not win last time is granted.
  // last_grant resets to 1 so port 0 wins the first tie.
  assign any_req   = req0 | req1;
  assign grant_sel = (req0 & req1) ? ~last_grant_q : req1;
  assign sel_addr  = grant_sel ? addr1 : addr0;
  assign data_last = (cnt_q == WAIT_LAST);

  // ALA is only entered from IDLE, where the address is not latched yet,
  // so the low word comes straight from the granted request there.
  assign lo_word = (state_q == S_IDLE) ? sel_addr[15:0] : addr_q[15:0];

  always_comb begin
    hi_word = '0;
    hi_word[ADDR_W-17:0] = addr_q[ADDR_W-1:16];
  end

  assign state = state_q;

  // State register and access context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_req) begin
        grant_q      <= grant_sel;
        last_grant_q <= grant_sel;
        addr_q       <= sel_addr;
        we_q         <= grant_sel & we1;  // port 0 is always a read
        be_q         <= be1;
        wdata_q      <= wdata1;
      end
      if (state_q == S_DATA) cnt_q <= cnt_q + 4'd1;
      else                   cnt_q <= '0;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ALA;
      S_ALA:   state_d = S_ALH;
      S_ALH:   state_d = S_AHA;
      S_AHA:   state_d = S_AHH;
      S_AHH:   state_d = S_DATA;
      S_DATA:  if (data_last) state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // register holds the value belonging to the state it is presented with.
  always_comb begin
    bus_out_d = bus_out;
    bus_dir_d = bus_dir;
    le_lo_d   = 1'b0;
    le_hi_d   = 1'b0;
    oeb_d     = 1'b1;
    web_lo_d  = 1'b1;
    web_hi_d  = 1'b1;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_d)
      S_IDLE: bus_dir_d = 1'b1;
      S_ALA: begin
        bus_dir_d = 1'b0;
        bus_out_d = lo_word;
        le_lo_d   = 1'b1;
      end
      S_ALH: bus_dir_d = 1'b0;
      S_AHA: begin
        bus_dir_d = 1'b0;
        bus_out_d = hi_word;
        le_hi_d   = 1'b1;
      end
      S_AHH: bus_dir_d = 1'b0;
      S_DATA: begin
        if (we_q) begin
          bus_dir_d = 1'b0;
          bus_out_d = wdata_q;
          web_lo_d  = ~be_q[0];
          web_hi_d  = ~be_q[1];
        end else begin
          bus_dir_d = 1'b1;
          oeb_d     = 1'b0;
        end
      end
      // END keeps bus_out/bus_dir from DATA for write data hold time.
      S_END: begin
        ack0_d = ~grant_q;
        ack1_d = grant_q;
      end
      default: bus_dir_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out <= '0;
      bus_dir <= 1'b1;
      le_lo   <= 1'b0;
      le_hi   <= 1'b0;
      OEb     <= 1'b1;
      WEb_lo  <= 1'b1;
      WEb_hi  <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata   <= '0;
    end else begin
      bus_out <= bus_out_d;
      bus_dir <= bus_dir_d;
      le_lo   <= le_lo_d;
      le_hi   <= le_hi_d;
      OEb     <= oeb_d;
      WEb_lo  <= web_lo_d;
      WEb_hi  <= web_hi_d;
      ack0    <= ack0_d;
      ack1    <= ack1_d;
      // Capture on the last strobe cycle so data is valid with the ack.
      if (state_q == S_DATA && data_last && !we_q) rdata <= bus_in;
    end
  end

endmodule
